// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one uart_tx.
// Grants in IDLE, holds tx_start until the transmitter goes busy, then waits for it to finish.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ACCEPT_TIMEOUT = 16,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = $clog2(ACCEPT_TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t               state_reg, state_next;
  logic [IDW-1:0]       ptr_reg, ptr_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 tx_start_reg, tx_start_next;
  logic [7:0]           tx_data_reg, tx_data_next;
  logic [IDW-1:0]       grant_id_reg, grant_id_next;
  logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 err_timeout_reg, err_timeout_next;

  logic [7:0]           req_byte [NUM_REQ];
  logic                 win_found;
  logic [IDW-1:0]       win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_byte
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Search starts one past the last grant and wraps, so the first hit is the round-robin winner.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr_reg) + i) % NUM_REQ;
      if (!win_found && req_valid[IDW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    cnt_next         = cnt_reg;
    tx_start_next    = tx_start_reg;
    tx_data_next     = tx_data_reg;
    grant_id_next    = grant_id_reg;
    req_ready_next   = '0;
    done_next        = 1'b0;
    err_timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next              = START;
          tx_data_next            = req_byte[win_idx];
          grant_id_next           = win_idx;
          ptr_next                = win_idx;
          req_ready_next[win_idx] = 1'b1;
          tx_start_next           = 1'b1;
          cnt_next                = '0;
        end
      end
      START: begin
        if (tx_busy) begin
          tx_start_next = 1'b0;
          cnt_next      = '0;
          state_next    = WAIT_DONE;
        end else if (cnt_reg == CW'(ACCEPT_TIMEOUT - 1)) begin
          // ACCEPT_TIMEOUT cycles of tx_start with no acceptance: give the slot up.
          tx_start_next    = 1'b0;
          err_timeout_next = 1'b1;
          cnt_next         = '0;
          state_next       = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        tx_start_next = 1'b0;
        state_next    = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= IDW'(NUM_REQ - 1);
      cnt_reg         <= '0;
      tx_start_reg    <= 1'b0;
      tx_data_reg     <= '0;
      grant_id_reg    <= '0;
      req_ready_reg   <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      cnt_reg         <= cnt_next;
      tx_start_reg    <= tx_start_next;
      tx_data_reg     <= tx_data_next;
      grant_id_reg    <= grant_id_next;
      req_ready_reg   <= req_ready_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  assign req_ready   = req_ready_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign grant_id    = grant_id_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy model.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = 32'h4433_A511;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done;
  logic        err_timeout;

  int tests_run = 0;
  int tests_failed = 0;

  // uart_tx model: busy rises 2 cycles after tx_start rises and stays high 10 cycles.
  logic model_en = 1'b0;
  logic m_active;
  int   m_cnt;

  uart_tx_arbiter #(.NUM_REQ(4), .ACCEPT_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_cnt <= 0; tx_busy <= 1'b0;
    end else if (!model_en) begin
      m_active <= 1'b0; tx_busy <= 1'b0;
    end else if (!m_active) begin
      if (tx_start) begin m_active <= 1'b1; m_cnt <= 1; end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 1) tx_busy <= 1'b1;
      if (m_cnt == 11) begin tx_busy <= 1'b0; m_active <= 1'b0; end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    tests_run++;
    if ({tx_start, busy, done, err_timeout} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_flags got %b want 0000", {tx_start, busy, done, err_timeout});
    end
    tests_run++;
    if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    tests_run++;
    if (grant_id !== 2'd0 || req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_grant got id=%0d ready=%b want 0/0000", grant_id, req_ready);
    end
    rst_n = 1'b1;
    repeat (3) step();
    tests_run++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      tests_failed++; $display("FAIL idle_no_req got busy=%b start=%b want 0/0", busy, tx_start);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    int starts = 0, dones = 0, errs = 0, unstable = 0;
    model_en = 1'b1;
    req_valid = 4'b0010;
    step();
    tests_run++;
    if (req_ready !== 4'b0010 || tx_start !== 1'b1 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL single_grant got ready=%b start=%b busy=%b want 0010/1/1", req_ready, tx_start, busy);
    end
    tests_run++;
    if (tx_data !== 8'hA5 || grant_id !== 2'd1) begin
      tests_failed++; $display("FAIL single_data got data=%h id=%0d want a5/1", tx_data, grant_id);
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && dones == 0; c++) begin
      if (tx_start) starts++;
      if (busy && (tx_data !== 8'hA5 || grant_id !== 2'd1)) unstable++;
      if (err_timeout) errs++;
      step();
      if (done) dones++;
    end
    repeat (3) begin step(); if (done) dones++; end
    tests_run++;
    if (starts !== 3) begin tests_failed++; $display("FAIL single_start_len got %0d want 3", starts); end
    tests_run++;
    if (dones !== 1 || errs !== 0) begin tests_failed++; $display("FAIL single_done got done=%0d err=%0d want 1/0", dones, errs); end
    tests_run++;
    if (unstable !== 0) begin tests_failed++; $display("FAIL single_stable got %0d unstable cycles want 0", unstable); end
    tests_run++;
    if (tx_data !== 8'hA5 || grant_id !== 2'd1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_hold got data=%h id=%0d busy=%b want a5/1/0", tx_data, grant_id, busy);
    end
    $display("[TB] single transfer id=%0d data=%h starts=%0d dones=%0d", grant_id, tx_data, starts, dones);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] exp_byte [4] = '{8'h11, 8'hA5, 8'h33, 8'h44};
    int grants = 0, dones = 0, bad_onehot = 0, doubles = 0, cycles = 0;
    do_reset();
    model_en = 1'b1;
    req_valid = 4'b1111;
    while (grants < 8 && cycles < 400) begin
      step();
      cycles++;
      if (done) dones++;
      if (req_ready != 4'b0000) begin
        if (req_ready !== (4'b0001 << grant_id)) bad_onehot++;
        if (grants != dones) doubles++;
        tests_run++;
        if (grant_id !== exp_id[grants] || tx_data !== exp_byte[exp_id[grants]]) begin
          tests_failed++;
          $display("FAIL rr_grant%0d got id=%0d data=%h want %0d/%h", grants, grant_id, tx_data, exp_id[grants], exp_byte[exp_id[grants]]);
        end
        $display("[TB] rr grant %0d id=%0d data=%h", grants, grant_id, tx_data);
        grants++;
      end
    end
    tests_run++;
    if (grants !== 8) begin tests_failed++; $display("FAIL rr_count got %0d grants want 8", grants); end
    tests_run++;
    if (bad_onehot !== 0 || doubles !== 0) begin
      tests_failed++; $display("FAIL rr_double got onehot_err=%0d double=%0d want 0/0", bad_onehot, doubles);
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && busy; c++) step();
  endtask

  task automatic test_timeout();
    int starts = 0, errs = 0, dones = 0, found = 0;
    model_en = 1'b0;
    req_valid = 4'b0001;
    step();
    tests_run++;
    if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
      tests_failed++; $display("FAIL to_grant got ready=%b id=%0d want 0001/0", req_ready, grant_id);
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && errs == 0; c++) begin
      if (tx_start) starts++;
      step();
      if (err_timeout) errs++;
      if (done) dones++;
    end
    repeat (3) begin step(); if (err_timeout) errs++; if (done) dones++; end
    tests_run++;
    if (starts !== 16) begin tests_failed++; $display("FAIL to_start_len got %0d want 16", starts); end
    tests_run++;
    if (errs !== 1 || dones !== 0) begin tests_failed++; $display("FAIL to_pulse got err=%0d done=%0d want 1/0", errs, dones); end
    tests_run++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      tests_failed++; $display("FAIL to_idle got busy=%b start=%b want 0/0", busy, tx_start);
    end
    $display("[TB] timeout starts=%0d err=%0d", starts, errs);
    model_en = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 10 && found == 0; c++) begin
      step();
      if (req_ready != 4'b0000) found = 1;
    end
    tests_run++;
    if (found !== 1 || grant_id !== 2'd1 || req_ready !== 4'b0010) begin
      tests_failed++; $display("FAIL to_next_grant got found=%0d id=%0d ready=%b want 1/1/0010", found, grant_id, req_ready);
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && busy; c++) step();
  endtask

  task automatic test_reset_mid();
    int dones = 0, found = 0, guard = 0;
    model_en = 1'b1;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    while (!(busy && !tx_start) && guard < 20) begin step(); guard++; end
    tests_run++;
    if (!(busy && !tx_start)) begin tests_failed++; $display("FAIL rm_reach_wait got busy=%b start=%b want 1/0", busy, tx_start); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({tx_start, busy, done, err_timeout, req_ready} !== 8'h00 || tx_data !== 8'h00 || grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL rm_async got start=%b busy=%b data=%h id=%0d want all zero", tx_start, busy, tx_data, grant_id);
    end
    repeat (2) begin step(); if (done) dones++; end
    rst_n = 1'b1;
    repeat (3) begin step(); if (done) dones++; end
    tests_run++;
    if (dones !== 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rm_quiet got done=%0d busy=%b want 0/0", dones, busy); end
    req_valid = 4'b0001;
    for (int c = 0; c < 5 && found == 0; c++) begin
      step();
      if (req_ready != 4'b0000) found = 1;
    end
    tests_run++;
    if (found !== 1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || tx_data !== 8'h11) begin
      tests_failed++; $display("FAIL rm_first_grant got ready=%b id=%0d data=%h want 0001/0/11", req_ready, grant_id, tx_data);
    end
    $display("[TB] reset mid-transfer, first grant id=%0d", grant_id);
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && busy; c++) step();
  endtask

  task automatic test_drop_during_wait();
    int guard = 0, early = 0, got_done = 0, unstable = 0;
    model_en = 1'b1;
    req_valid = 4'b1100;
    step();
    tests_run++;
    if (req_ready !== 4'b0100 || grant_id !== 2'd2 || tx_data !== 8'h33) begin
      tests_failed++; $display("FAIL dr_grant got ready=%b id=%0d data=%h want 0100/2/33", req_ready, grant_id, tx_data);
    end
    while (!(busy && !tx_start) && guard < 20) begin step(); guard++; end
    req_valid = 4'b1000;
    for (int c = 0; c < 40 && got_done == 0; c++) begin
      step();
      if (req_ready != 4'b0000) early++;
      if (busy && (tx_data !== 8'h33 || grant_id !== 2'd2)) unstable++;
      if (done) got_done = 1;
    end
    tests_run++;
    if (got_done !== 1 || early !== 0 || unstable !== 0) begin
      tests_failed++; $display("FAIL dr_complete got done=%0d early=%0d unstable=%0d want 1/0/0", got_done, early, unstable);
    end
    step();
    tests_run++;
    if (req_ready !== 4'b1000 || grant_id !== 2'd3 || tx_data !== 8'h44) begin
      tests_failed++; $display("FAIL dr_next got ready=%b id=%0d data=%h want 1000/3/44", req_ready, grant_id, tx_data);
    end
    $display("[TB] drop during wait, next grant id=%0d", grant_id);
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && busy; c++) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_drop_during_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
